// File: rtl/count_monitor.sv
// Watches a 3-bit up/down counter and checks that each sample follows its predecessor.
// Reports matches, wraps and mismatches, counts errors, and latches FAULT on repeated misses.
module count_monitor #(
  parameter int unsigned ERR_W   = 8,
  parameter int unsigned FAULT_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mod,
  input  logic [2:0]       count,
  input  logic             clr_err,
  output logic             match,
  output logic             mismatch,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked,
  output logic             fault
);

  typedef enum logic [1:0] {StIdle, StSync, StTrack, StFault} state_e;

  localparam logic [ERR_W-1:0] ErrMax = '1;
  localparam logic [ERR_W-1:0] ErrOne = ERR_W'(1);

  state_e             state_q, state_d;
  logic [2:0]         prev_count_q, prev_count_d;
  logic               prev_mod_q, prev_mod_d;
  logic [1:0]         miss_q, miss_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               match_q, match_d;
  logic               mismatch_q, mismatch_d;
  logic               wrap_up_q, wrap_up_d;
  logic               wrap_dn_q, wrap_dn_d;
  logic               locked_q, locked_d;
  logic               fault_q, fault_d;

  logic [2:0] exp_count;
  logic       compare;
  logic       equal;
  logic       miss_hit;

  assign exp_count = prev_mod_q ? 3'(prev_count_q + 3'd1) : 3'(prev_count_q - 3'd1);
  assign compare   = en && (state_q == StTrack);
  assign equal     = (count == exp_count);
  // This miss would bring the consecutive run up to the fault threshold.
  assign miss_hit  = (32'(miss_q) + 32'd1) >= FAULT_N;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StSync;
      StSync:  state_d = en ? StTrack : StIdle;
      StTrack: begin
        if (!en) begin
          state_d = StIdle;
        end else if (!equal && miss_hit) begin
          state_d = StFault;
        end
      end
      StFault: if (!en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    prev_count_d = en ? count : prev_count_q;
    prev_mod_d   = en ? mod : prev_mod_q;
    match_d      = compare && equal;
    mismatch_d   = compare && !equal;
    wrap_up_d    = compare && equal && prev_mod_q && (prev_count_q == 3'd7);
    wrap_dn_d    = compare && equal && !prev_mod_q && (prev_count_q == 3'd0);
    // Consecutive-miss run only lives while tracking; any resync starts it afresh.
    if (compare) begin
      miss_d = equal ? 2'd0 : 2'(miss_q + 2'd1);
    end else begin
      miss_d = 2'd0;
    end
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = mismatch_d ? ErrOne : '0;
    end else if (mismatch_d && (err_cnt_q != ErrMax)) begin
      err_cnt_d = err_cnt_q + ErrOne;
    end
    locked_d = (state_d == StTrack);
    fault_d  = (state_d == StFault);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_count_q <= 3'd0;
      prev_mod_q   <= 1'b0;
      miss_q       <= 2'd0;
      err_cnt_q    <= '0;
      match_q      <= 1'b0;
      mismatch_q   <= 1'b0;
      wrap_up_q    <= 1'b0;
      wrap_dn_q    <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      prev_count_q <= prev_count_d;
      prev_mod_q   <= prev_mod_d;
      miss_q       <= miss_d;
      err_cnt_q    <= err_cnt_d;
      match_q      <= match_d;
      mismatch_q   <= mismatch_d;
      wrap_up_q    <= wrap_up_d;
      wrap_dn_q    <= wrap_dn_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

  assign match    = match_q;
  assign mismatch = mismatch_q;
  assign wrap_up  = wrap_up_q;
  assign wrap_dn  = wrap_dn_q;
  assign err_cnt  = err_cnt_q;
  assign locked   = locked_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed plus randomized bench for count_monitor, checked against a sample-history model.
module tb_count_monitor;

  localparam int unsigned ERR_W   = 8;
  localparam int unsigned FAULT_N = 3;
  localparam int          ErrMax  = (1 << ERR_W) - 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic             mod;
  logic [2:0]       count;
  logic             clr_err;
  logic             match;
  logic             mismatch;
  logic             wrap_up;
  logic             wrap_dn;
  logic [ERR_W-1:0] err_cnt;
  logic             locked;
  logic             fault;

  count_monitor #(
    .ERR_W  (ERR_W),
    .FAULT_N(FAULT_N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mod     (mod),
    .count   (count),
    .clr_err (clr_err),
    .match   (match),
    .mismatch(mismatch),
    .wrap_up (wrap_up),
    .wrap_dn (wrap_dn),
    .err_cnt (err_cnt),
    .locked  (locked),
    .fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: number of valid samples since the last resync, last sample, fault latch.
  int m_seen;
  int m_prev;
  bit m_pmod;
  bit m_fault;
  int m_miss;
  int m_err;
  bit m_match, m_mm, m_wu, m_wd, m_locked;

  int wrap_up_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_prev = 0; m_pmod = 0; m_fault = 0; m_miss = 0; m_err = 0;
    m_match = 0; m_mm = 0; m_wu = 0; m_wd = 0; m_locked = 0;
  endtask

  function automatic int predict();
    return (m_prev + (m_pmod ? 1 : 7)) % 8;
  endfunction

  task automatic model_edge(input bit e, input bit md, input int c, input bit cl);
    m_match = 0; m_mm = 0; m_wu = 0; m_wd = 0;
    if (!e) begin
      m_seen = 0; m_fault = 0; m_miss = 0;
    end else begin
      if (!m_fault && m_seen >= 2) begin
        if (c == predict()) begin
          m_match = 1;
          m_miss  = 0;
          m_wu    = m_pmod && (m_prev == 7);
          m_wd    = !m_pmod && (m_prev == 0);
        end else begin
          m_mm = 1;
          m_miss++;
          if (m_miss >= FAULT_N) m_fault = 1;
        end
      end else if (!m_fault) begin
        m_seen++;
      end
      m_prev = c;
      m_pmod = md;
    end
    if (cl) m_err = m_mm ? 1 : 0;
    else if (m_mm && m_err < ErrMax) m_err++;
    m_locked = e && !m_fault && (m_seen >= 2);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".match"},    32'(match),    32'(m_match));
    chk({tag, ".mismatch"}, 32'(mismatch), 32'(m_mm));
    chk({tag, ".wrap_up"},  32'(wrap_up),  32'(m_wu));
    chk({tag, ".wrap_dn"},  32'(wrap_dn),  32'(m_wd));
    chk({tag, ".err_cnt"},  32'(err_cnt),  32'(m_err));
    chk({tag, ".locked"},   32'(locked),   32'(m_locked));
    chk({tag, ".fault"},    32'(fault),    32'(m_fault));
  endtask

  // Inputs change on the falling edge; outputs are checked on the following falling edge.
  task automatic step(input string tag, input bit e, input bit md, input int c, input bit cl);
    en = e; mod = md; count = 3'(c); clr_err = cl;
    @(posedge clk);
    model_edge(e, md, c, cl);
    @(negedge clk);
    if (wrap_up === 1'b1) wrap_up_seen++;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 0; mod = 0; count = 0; clr_err = 0;
    model_reset();
    wrap_up_seen = 0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    @(negedge clk);
    check_all("reset_idle");

    // Clean up-count with a 7->0 wrap.
    for (int i = 0; i <= 8; i++) step("up_seq", 1, 1, i % 8, 0);
    chk("up_seq.wrap_up_pulses", 32'(wrap_up_seen), 32'd1);
    chk("up_seq.err_zero", 32'(err_cnt), 32'd0);

    // Down-count across the 0->7 wrap.
    step("dn_break", 0, 0, 0, 0);
    step("dn_seq", 1, 0, 2, 0);
    step("dn_seq", 1, 0, 1, 0);
    step("dn_seq", 1, 0, 0, 0);
    step("dn_seq", 1, 0, 7, 0);
    chk("dn_seq.wrap_dn", 32'(wrap_dn), 32'd1);

    // Skipped value: one mismatch, then prediction restarts from the bad sample.
    step("skip_break", 0, 1, 0, 0);
    step("skip", 1, 1, 2, 0);
    step("skip", 1, 1, 3, 0);
    step("skip", 1, 1, 4, 0);
    step("skip", 1, 1, 6, 0);
    chk("skip.err_one", 32'(err_cnt), 32'd1);
    step("skip", 1, 1, 7, 0);
    chk("skip.locked", 32'(locked), 32'd1);

    // Three consecutive misses force FAULT.
    step("fault_clr", 0, 1, 0, 1);
    step("fault", 1, 1, 2, 0);
    step("fault", 1, 1, 3, 0);
    step("fault", 1, 1, 5, 0);
    step("fault", 1, 1, 0, 0);
    step("fault", 1, 1, 3, 0);
    chk("fault.fault", 32'(fault), 32'd1);
    chk("fault.err_three", 32'(err_cnt), 32'd3);
    step("fault_hold", 1, 1, 4, 0);
    step("fault_exit", 0, 1, 4, 0);
    chk("fault_exit.fault", 32'(fault), 32'd0);

    // clr_err alongside a mismatch leaves one error; clr_err alone clears.
    step("clr", 1, 1, 0, 0);
    step("clr", 1, 1, 1, 0);
    step("clr", 1, 1, 5, 0);
    chk("clr.err_four", 32'(err_cnt), 32'd4);
    step("clr_mm", 1, 1, 2, 1);
    chk("clr_mm.err_one", 32'(err_cnt), 32'd1);
    step("clr_only", 1, 1, 3, 1);
    chk("clr_only.err_zero", 32'(err_cnt), 32'd0);

    // Reset between edges mid-TRACK; first compare on the third en=1 edge after release.
    step("rst_pre", 1, 1, 4, 0);
    async_reset("rst_mid");
    step("rst_post1", 1, 1, 6, 0);
    step("rst_post2", 1, 1, 1, 0);
    step("rst_post3", 1, 1, 5, 0);
    chk("rst_post3.mismatch", 32'(mismatch), 32'd1);

    // Saturation: alternate miss/hit so FAULT is never reached.
    step("sat_break", 0, 1, 0, 0);
    step("sat", 1, 1, 0, 0);
    step("sat", 1, 1, 1, 0);
    for (int i = 0; i < 270; i++) begin
      step("sat_bad", 1, 1, (predict() + 3) % 8, 0);
      step("sat_good", 1, 1, predict(), 0);
    end
    chk("sat.err_max", 32'(err_cnt), 32'(ErrMax));

    // Randomized traffic, mostly well-behaved counts.
    for (int i = 0; i < 1500; i++) begin
      bit e, md, cl;
      int c;
      e  = ($urandom_range(0, 19) != 0);
      md = ($urandom_range(0, 7) != 0) ? m_pmod : 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : predict();
      cl = ($urandom_range(0, 40) == 0);
      step("rand", e, md, c, cl);
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
